glyph_plotter: RTL and testbench

Sequential rasteriser that takes a 128-bit 8x16 glyph bitmap from the character decoder, plus a text-cell position, and writes the glyph one pixel per cycle into the VGA adapter's pixel-write port. It sits between the notepad's text buffer/cursor logic and the 160x120 VGA adapter. It is the consumer end of the decoder's glyph bus.

---
 rtl/notepad_pkg.sv | 41 ++++
 rtl/glyph_scan_counter.sv | 41 ++++
 rtl/glyph_plotter.sv | 171 +++++++++++++++++
 tb/tb_glyph_plotter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/notepad_pkg.sv
// Shared constants, state encoding and screen-coordinate helpers for the notepad
// text-to-VGA path (character decoder, glyph plotter, VGA adapter).
package notepad_pkg;

    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int COLS     = 20;
    localparam int ROWS     = 7;
    localparam int GLYPH_W  = CHAR_W * CHAR_H;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam int COL_W    = 5;
    localparam int ROW_W    = 3;
    localparam int C_W      = 3;
    localparam int R_W      = 4;
    localparam int P_W      = C_W + R_W;

    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } plot_state_e;

    // Cells are 8x16 aligned, so col*8+c and row*16+r reduce to concatenations.
    function automatic logic [X_W-1:0] pixel_x(input logic [COL_W-1:0] col,
                                               input logic [C_W-1:0]   c);
        return {col, c};
    endfunction

    function automatic logic [Y_W-1:0] pixel_y(input logic [ROW_W-1:0] row,
                                               input logic [R_W-1:0]   r);
        return {row, r};
    endfunction

endpackage

// File: rtl/glyph_scan_counter.sv
// Pixel index counter for one glyph scan: p = {r, c}, clear has priority over
// enable, tc flags the last pixel of the cell.
module glyph_scan_counter
    import notepad_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           en,
    output logic [P_W-1:0] p,
    output logic [R_W-1:0] r,
    output logic [C_W-1:0] c,
    output logic           tc
);

    logic [P_W-1:0] p_q;
    logic [P_W-1:0] p_d;

    always_comb begin
        p_d = p_q;
        if (clr) begin
            p_d = '0;
        end else if (en) begin
            p_d = p_q + P_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p  = p_q;
    assign r  = p_q[P_W-1:C_W];
    assign c  = p_q[C_W-1:0];
    assign tc = (p_q == {P_W{1'b1}});

endmodule

// File: rtl/glyph_plotter.sv
// Rasterises one latched 8x16 glyph into the VGA pixel-write port, one pixel per
// cycle, with a one-cycle DONE pulse; a new request may be taken in the DONE cycle.
module glyph_plotter
    import notepad_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [GLYPH_W-1:0]  GLYPH,
    input  logic [COL_W-1:0]    COL,
    input  logic [ROW_W-1:0]    ROW,
    input  logic [COLOUR_W-1:0] FG,
    input  logic [COLOUR_W-1:0] BG,
    output logic [X_W-1:0]      X,
    output logic [Y_W-1:0]      Y,
    output logic [COLOUR_W-1:0] COLOUR,
    output logic                PLOT,
    output logic                BUSY,
    output logic                DONE,
    output plot_state_e         DBG_STATE
);

    plot_state_e         state_q,  state_d;
    logic [GLYPH_W-1:0]  glyph_q,  glyph_d;
    logic [COL_W-1:0]    col_q,    col_d;
    logic [ROW_W-1:0]    row_q,    row_d;
    logic [COLOUR_W-1:0] fg_q,     fg_d;
    logic [COLOUR_W-1:0] bg_q,     bg_d;
    logic [X_W-1:0]      x_q,      x_d;
    logic [Y_W-1:0]      y_q,      y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q,   plot_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                last_q,   last_d;

    logic           can_accept;
    logic           accept;
    logic           in_range;
    logic           scan_en;
    logic           scan_clr;
    logic [P_W-1:0] scan_p;
    logic [R_W-1:0] scan_r;
    logic [C_W-1:0] scan_c;
    logic           scan_tc;

    // FIN without DONE is the wait cycle of an out-of-range request; only the
    // DONE cycle of FIN behaves like IDLE.
    assign can_accept = (state_q == IDLE) || ((state_q == FIN) && done_q);
    assign accept     = START && can_accept;
    assign in_range   = (COL < COL_LIMIT) && (ROW < ROW_LIMIT);

    // Pixel 0 is emitted straight from the request inputs while the counter
    // steps to 1, so the counter always indexes the pixel emitted at this edge.
    assign scan_en  = (accept && in_range) || ((state_q == DRAW) && !last_q);
    assign scan_clr = !scan_en;

    glyph_scan_counter u_scan (
        .clk   (CLK),
        .reset (RESET),
        .clr   (scan_clr),
        .en    (scan_en),
        .p     (scan_p),
        .r     (scan_r),
        .c     (scan_c),
        .tc    (scan_tc)
    );

    always_comb begin
        state_d  = state_q;
        glyph_d  = glyph_q;
        col_d    = col_q;
        row_d    = row_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        last_d   = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                if ((state_q == FIN) && !done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (accept) begin
                    glyph_d = GLYPH;
                    col_d   = COL;
                    row_d   = ROW;
                    fg_d    = FG;
                    bg_d    = BG;
                    busy_d  = 1'b1;
                    if (in_range) begin
                        state_d  = DRAW;
                        x_d      = pixel_x(COL, '0);
                        y_d      = pixel_y(ROW, '0);
                        colour_d = GLYPH[GLYPH_W-1] ? FG : BG;
                        plot_d   = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            DRAW: begin
                if (last_q) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    x_d      = pixel_x(col_q, scan_c);
                    y_d      = pixel_y(row_q, scan_r);
                    colour_d = glyph_q[~scan_p] ? fg_q : bg_q;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    last_d   = scan_tc;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            glyph_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            glyph_q  <= glyph_d;
            col_q    <= col_d;
            row_q    <= row_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            last_q   <= last_d;
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign COLOUR    = colour_q;
    assign PLOT      = plot_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Bench for glyph_plotter: directed requests push timed pixel and DONE
// expectations; a negedge monitor pops and compares them as the DUT presents output.
module tb_glyph_plotter;
    import notepad_pkg::*;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic [127:0]  GLYPH;
    logic [4:0]    COL;
    logic [2:0]    ROW;
    logic [2:0]    FG;
    logic [2:0]    BG;
    logic [7:0]    X;
    logic [6:0]    Y;
    logic [2:0]    COLOUR;
    logic          PLOT;
    logic          BUSY;
    logic          DONE;
    plot_state_e   DBG_STATE;

    glyph_plotter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .GLYPH     (GLYPH),
        .COL       (COL),
        .ROW       (ROW),
        .FG        (FG),
        .BG        (BG),
        .X         (X),
        .Y         (Y),
        .COLOUR    (COLOUR),
        .PLOT      (PLOT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    int plot_cnt    = 0;
    logic [49:0] exp_q[$];   // {cycle[31:0], x[7:0], y[6:0], colour[2:0]}
    int          done_q[$];  // expected DONE cycles

    localparam logic [127:0] GLYPH_A    = 128'h00183C66667E66666666000000000000;
    localparam logic [127:0] GLYPH_ONES = {128{1'b1}};
    localparam logic [127:0] GLYPH_L    = 128'hF00F_A55A_0FF0_C33C_8001_7FFE_1248_8421;
    localparam logic [127:0] GLYPH_B2   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pixel p of the cell appears in cycle base+1+p.
    task automatic push_exp(input logic [127:0] g, input int col, input int row,
                            input int fg, input int bg, input int base);
        logic [31:0] cc;
        logic [7:0]  xx;
        logic [6:0]  yy;
        logic [2:0]  cl;
        if (col < 20 && row < 7) begin
            for (int p = 0; p < 128; p++) begin
                cc = 32'(base + 1 + p);
                xx = 8'(col * 8 + (p % 8));
                yy = 7'(row * 16 + (p / 8));
                cl = g[127 - p] ? 3'(fg) : 3'(bg);
                exp_q.push_back({cc, xx, yy, cl});
            end
            done_q.push_back(base + 129);
        end else begin
            done_q.push_back(base + 2);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic go_to(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic issue(input logic [127:0] g, input int col, input int row,
                         input int fg, input int bg, output int k);
        @(negedge CLK);
        k     = cyc;
        START = 1'b1;
        GLYPH = g;
        COL   = 5'(col);
        ROW   = 3'(row);
        FG    = 3'(fg);
        BG    = 3'(bg);
        push_exp(g, col, row, fg, bg, k);
        @(negedge CLK);
        START = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (!RESET) begin
            while (exp_q.size() > 0 && int'(exp_q[0][49:18]) < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_pixel: expected pixel %0h never plotted (now cycle %0d)",
                         exp_q[0], cyc);
                void'(exp_q.pop_front());
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_done: DONE expected at cycle %0d not seen", done_q[0]);
                void'(done_q.pop_front());
            end
            if (PLOT) begin
                plot_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_plot at cycle %0d: x=%0d y=%0d colour=%0d, none expected",
                             cyc, X, Y, COLOUR);
                end else begin
                    check("pixel", {32'(cyc), X, Y, COLOUR}, exp_q.pop_front());
                end
            end
            if (DONE) begin
                check("busy_at_done", BUSY, 1'b0);
                if (done_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done at cycle %0d: DONE=1, none expected", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        RESET = 1'b1;
        START = 1'b0;
        GLYPH = '0;
        COL   = '0;
        ROW   = '0;
        FG    = '0;
        BG    = '0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {X, Y, COLOUR, PLOT, BUSY, DONE}, 64'h0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Glyph 'A' at cell (2,1), plus an ignored START mid-draw.
        issue(GLYPH_A, 2, 1, 7, 0, k);
        check("a_first_pixel", {PLOT, BUSY, X, Y, COLOUR}, {1'b1, 1'b1, 8'd16, 7'd16, 3'd0});
        go_to(k + 12);
        check("a_pixel_19_17", {X, Y, COLOUR}, {8'd19, 7'd17, 3'd7});
        go_to(k + 13);
        check("a_pixel_20_17", {X, Y, COLOUR}, {8'd20, 7'd17, 3'd7});
        go_to(k + 50);
        START = 1'b1;
        GLYPH = GLYPH_ONES;
        COL   = 5'd0;
        ROW   = 3'd0;
        FG    = 3'd3;
        BG    = 3'd3;
        @(negedge CLK);
        START = 1'b0;
        go_to(k + 128);
        check("a_last_pixel", {PLOT, X, Y}, {1'b1, 8'd23, 7'd31});
        go_to(k + 129);
        check("a_done", {DONE, BUSY, PLOT}, {1'b1, 1'b0, 1'b0});
        go_to(k + 130);
        check("a_done_one_cycle", {DONE, BUSY, PLOT}, 3'b000);
        go_to(k + 132);

        // All-ones glyph in the bottom-right cell.
        plot_cnt = 0;
        issue(GLYPH_ONES, 19, 6, 2, 5, k);
        check("ones_first_xy", {X, Y}, {8'd152, 7'd96});
        go_to(k + 128);
        check("ones_last_pixel", {X, Y, COLOUR}, {8'd159, 7'd111, 3'd2});
        go_to(k + 131);
        check("ones_plot_count", plot_cnt, 128);

        // Out-of-range column, then row.
        plot_cnt = 0;
        issue(GLYPH_ONES, 20, 0, 1, 1, k);
        check("oor_col_busy", {BUSY, DONE, PLOT}, 3'b100);
        go_to(k + 2);
        check("oor_col_done", {DONE, BUSY}, 2'b10);
        go_to(k + 4);
        issue(GLYPH_ONES, 0, 7, 1, 1, k);
        check("oor_row_busy", {BUSY, DONE, PLOT}, 3'b100);
        go_to(k + 2);
        check("oor_row_done", {DONE, BUSY}, 2'b10);
        go_to(k + 4);
        check("oor_plot_count", plot_cnt, 0);

        // Inputs change one cycle after acceptance; pixels must use latched values.
        issue(GLYPH_L, 5, 3, 4, 1, k);
        GLYPH = ~GLYPH_L;
        COL   = 5'd11;
        FG    = 3'd6;
        go_to(k + 132);

        // START held high: second glyph accepted in the first glyph's DONE cycle.
        @(negedge CLK);
        k     = cyc;
        START = 1'b1;
        GLYPH = GLYPH_L;
        COL   = 5'd0;
        ROW   = 3'd0;
        FG    = 3'd1;
        BG    = 3'd6;
        push_exp(GLYPH_L, 0, 0, 1, 6, k);
        push_exp(GLYPH_B2, 10, 4, 3, 4, k + 129);
        @(negedge CLK);
        GLYPH = GLYPH_B2;
        COL   = 5'd10;
        ROW   = 3'd4;
        FG    = 3'd3;
        BG    = 3'd4;
        go_to(k + 129);
        check("b2b_first_done", {DONE, BUSY}, 2'b10);
        go_to(k + 130);
        START = 1'b0;
        check("b2b_second_start", {PLOT, BUSY, X, Y}, {1'b1, 1'b1, 8'd80, 7'd64});
        go_to(k + 258);
        check("b2b_second_done", DONE, 1'b1);
        go_to(k + 261);

        // Reset in cycle k+40 of a draw.
        issue(GLYPH_A, 3, 2, 5, 2, k);
        go_to(k + 40);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_mid_draw", {PLOT, BUSY, DONE, X, Y, COLOUR}, 64'h0);
        exp_q.delete();
        done_q.delete();
        RESET = 1'b0;
        go_to(k + 200);
        check("reset_idle_state", {PLOT, BUSY, DONE}, 3'b000);

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", exp_q.size() + done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
